// File: rtl/div_arbiter.sv
// div_arbiter: round-robin two-requester front end for the shared iterative
// divide unit. Accepts one op at a time, latches operands, pulses the divider
// start, waits for done (with a watchdog), and returns the result to the
// owning requester. Requester kills discard the in-flight result.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o      per-requester request handshake (2 bits)
//   req_a_i/req_b_i/req_op_i     packed operands / funct3, requester i in slice i
//   kill_i                       per-requester flush
//   rsp_valid_o/rsp_ready_i      per-requester response handshake
//   rsp_data_o                   shared result bus, zero when no response
//   div_start_o/div_a_o/div_b_o/div_op_o   divide unit issue side
//   div_result_i/div_done_i      divide unit completion side
//   busy_o/owner_o/timeout_o     status
module div_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [2*XLEN-1:0] req_a_i,
  input  logic [2*XLEN-1:0] req_b_i,
  input  logic [5:0]        req_op_i,
  input  logic [1:0]        kill_i,
  output logic [1:0]        rsp_valid_o,
  output logic [XLEN-1:0]   rsp_data_o,
  input  logic [1:0]        rsp_ready_i,
  output logic              div_start_o,
  output logic [XLEN-1:0]   div_a_o,
  output logic [XLEN-1:0]   div_b_o,
  output logic [2:0]        div_op_o,
  input  logic [XLEN-1:0]   div_result_i,
  input  logic              div_done_i,
  output logic              busy_o,
  output logic              owner_o,
  output logic              timeout_o
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q;
  logic              owner_q;
  logic              rr_q;
  logic              killed_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   res_q;
  logic [WD_W-1:0]   wd_q;

  logic [1:0]        eligible;
  logic              gnt_valid;
  logic              gnt_idx;
  logic              own_kill;
  logic              own_ready;
  logic              wd_expired;

  // Arbitration: rr_q breaks ties, otherwise the lone eligible requester wins.
  always_comb begin
    eligible   = req_valid_i & ~kill_i;
    gnt_valid  = |eligible;
    gnt_idx    = (&eligible) ? rr_q : eligible[1];
    own_kill   = kill_i[owner_q];
    own_ready  = rsp_ready_i[owner_q];
    wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    req_ready_o = 2'b00;
    if (state_q == S_IDLE && gnt_valid) begin
      req_ready_o[gnt_idx] = 1'b1;
    end

    // A kill in RESP suppresses the response in the same cycle.
    rsp_valid_o = 2'b00;
    rsp_data_o  = '0;
    if (state_q == S_RESP && !own_kill) begin
      rsp_valid_o[owner_q] = 1'b1;
      rsp_data_o           = res_q;
    end

    timeout_o = (state_q == S_WAIT) && !div_done_i && wd_expired;
  end

  assign div_start_o = (state_q == S_ISSUE);
  assign div_a_o     = a_q;
  assign div_b_o     = b_q;
  assign div_op_o    = op_q;
  assign busy_o      = (state_q != S_IDLE);
  assign owner_o     = owner_q;

  // Sequencer state and datapath latches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      killed_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      wd_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            a_q      <= gnt_idx ? req_a_i[2*XLEN-1:XLEN] : req_a_i[XLEN-1:0];
            b_q      <= gnt_idx ? req_b_i[2*XLEN-1:XLEN] : req_b_i[XLEN-1:0];
            op_q     <= gnt_idx ? req_op_i[5:3] : req_op_i[2:0];
            owner_q  <= gnt_idx;
            rr_q     <= ~gnt_idx;
            killed_q <= 1'b0;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
          if (own_kill) killed_q <= 1'b1;
        end
        S_WAIT: begin
          if (div_done_i) begin
            // Kill wins over a simultaneous done.
            if (killed_q || own_kill) begin
              state_q <= S_IDLE;
            end else begin
              res_q   <= div_result_i;
              state_q <= S_RESP;
            end
          end else if (wd_expired) begin
            state_q <= S_IDLE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
            if (own_kill) killed_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (own_kill || own_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: stimulus pushes expected responses into a
// queue; a monitor pops and compares on every response handshake.
module tb_div_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TMO  = 16;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*XLEN-1:0] req_a;
  logic [2*XLEN-1:0] req_b;
  logic [5:0]        req_op;
  logic [1:0]        kill;
  logic [1:0]        rsp_valid;
  logic [XLEN-1:0]   rsp_data;
  logic [1:0]        rsp_ready;
  logic              div_start;
  logic [XLEN-1:0]   div_a;
  logic [XLEN-1:0]   div_b;
  logic [2:0]        div_op;
  logic [XLEN-1:0]   div_result;
  logic              div_done;
  logic              busy;
  logic              owner;
  logic              timeout;

  div_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_op_i    (req_op),
    .kill_i      (kill),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_ready_i (rsp_ready),
    .div_start_o (div_start),
    .div_a_o     (div_a),
    .div_b_o     (div_b),
    .div_op_o    (div_op),
    .div_result_i(div_result),
    .div_done_i  (div_done),
    .busy_o      (busy),
    .owner_o     (owner),
    .timeout_o   (timeout)
  );

  typedef struct packed {
    logic            lane;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push_exp(input logic lane, input logic [XLEN-1:0] data);
    exp_t e;
    e.lane = lane;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Response monitor: one-hot valid, data zero when idle, scoreboard on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid != 2'b00) begin
        chk("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
        if ((rsp_valid & rsp_ready) != 2'b00) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_unexpected: got valid %b data %0h expected no response", rsp_valid, rsp_data);
          end else begin
            exp_t e;
            logic [1:0] lane_oh;
            e = exp_q.pop_front();
            lane_oh = e.lane ? 2'b10 : 2'b01;
            chk("rsp_lane", 64'(rsp_valid), 64'(lane_oh));
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
          end
        end
      end else begin
        chk("rsp_data_idle", 64'(rsp_data), 64'd0);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b00;
    kill       = 2'b00;
    rsp_ready  = 2'b11;
    div_done   = 1'b0;
    div_result = '0;
    // lane 0: 100 / 7 (DIV), lane 1: 81 / 9 (DIVU)
    req_a  = {32'd81, 32'd100};
    req_b  = {32'd9, 32'd7};
    req_op = {3'd5, 3'd4};

    // Reset state
    tick();
    tick();
    settle();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(div_start), 64'd0);
    chk("rst_div_a", 64'(div_a), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    tick();

    // Single op on lane 0, done 5 cycles after start
    req_valid = 2'b01;
    settle();
    chk("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    settle();
    chk("t1_start", 64'(div_start), 64'd1);
    chk("t1_div_a", 64'(div_a), 64'd100);
    chk("t1_div_b", 64'(div_b), 64'd7);
    chk("t1_div_op", 64'(div_op), 64'd4);
    chk("t1_owner", 64'(owner), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    push_exp(1'b0, 32'd14);
    for (int i = 0; i < 4; i++) begin
      tick();
      settle();
      chk("t1_start_low", 64'(div_start), 64'd0);
    end
    tick();
    div_done   = 1'b1;
    div_result = 32'd14;
    settle();
    chk("t1_no_rsp_yet", 64'(rsp_valid), 64'd0);
    tick();
    div_done = 1'b0;
    settle();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t1_rsp_data", 64'(rsp_data), 64'd14);
    tick();
    settle();
    chk("t1_idle", 64'(busy), 64'd0);

    // Contention from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic ln;
      logic [1:0] oh;
      ln = (k % 2 == 1);
      oh = ln ? 2'b10 : 2'b01;
      settle();
      chk("t2_grant", 64'(req_ready), 64'(oh));
      tick();
      settle();
      chk("t2_start", 64'(div_start), 64'd1);
      chk("t2_ready_busy", 64'(req_ready), 64'd0);
      chk("t2_owner", 64'(owner), 64'(ln));
      chk("t2_div_a", 64'(div_a), ln ? 64'd81 : 64'd100);
      push_exp(ln, ln ? 32'd9 : 32'd14);
      tick();
      div_done   = 1'b1;
      div_result = ln ? 32'd9 : 32'd14;
      tick();
      div_done = 1'b0;
      settle();
      chk("t2_rsp_valid", 64'(rsp_valid), 64'(oh));
      tick();
    end
    req_valid = 2'b00;

    // Kill in WAIT on lane 1
    req_valid = 2'b10;
    settle();
    chk("t3_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    settle();
    chk("t3_start", 64'(div_start), 64'd1);
    tick();
    tick();
    kill = 2'b10;
    tick();
    kill = 2'b00;
    tick();
    div_done   = 1'b1;
    div_result = 32'd9;
    settle();
    chk("t3_busy_at_done", 64'(busy), 64'd1);
    tick();
    div_done = 1'b0;
    settle();
    chk("t3_no_rsp", 64'(rsp_valid), 64'd0);
    chk("t3_busy_fall", 64'(busy), 64'd0);

    // Kill coincident with done on lane 0
    req_valid = 2'b01;
    settle();
    chk("t4_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    div_done   = 1'b1;
    div_result = 32'd14;
    kill       = 2'b01;
    settle();
    chk("t4_no_rsp_now", 64'(rsp_valid), 64'd0);
    tick();
    div_done = 1'b0;
    kill     = 2'b00;
    settle();
    chk("t4_no_rsp", 64'(rsp_valid), 64'd0);
    chk("t4_idle", 64'(busy), 64'd0);

    // Backpressure on lane 0, lane 1 waits
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    settle();
    chk("t5_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b10;
    push_exp(1'b0, 32'd14);
    settle();
    chk("t5_ready_issue", 64'(req_ready), 64'd0);
    tick();
    div_done   = 1'b1;
    div_result = 32'd14;
    tick();
    div_done   = 1'b0;
    div_result = 32'hdead_beef;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t5_hold_valid", 64'(rsp_valid), 64'h1);
      chk("t5_hold_data", 64'(rsp_data), 64'd14);
      chk("t5_no_accept", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 2'b01;
    settle();
    chk("t5_final_valid", 64'(rsp_valid), 64'h1);
    chk("t5_no_accept_ready", 64'(req_ready), 64'd0);
    tick();
    rsp_ready = 2'b11;
    settle();
    chk("t5_req1_accept", 64'(req_ready), 64'h2);

    // Timeout: lane 1 op never completes
    tick();
    req_valid = 2'b00;
    settle();
    chk("t6_start", 64'(div_start), 64'd1);
    chk("t6_owner", 64'(owner), 64'd1);
    for (int w = 1; w <= int'(TMO); w++) begin
      tick();
      settle();
      chk("t6_timeout", 64'(timeout), (w == int'(TMO)) ? 64'd1 : 64'd0);
    end
    tick();
    settle();
    chk("t6_idle", 64'(busy), 64'd0);
    chk("t6_pulse_end", 64'(timeout), 64'd0);

    // Reset in WAIT, then a late done
    req_valid = 2'b01;
    settle();
    chk("t7_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    tick();
    settle();
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_start", 64'(div_start), 64'd0);
    chk("t7_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t7_rsp_data", 64'(rsp_data), 64'd0);
    chk("t7_div_a", 64'(div_a), 64'd0);
    chk("t7_div_b", 64'(div_b), 64'd0);
    chk("t7_div_op", 64'(div_op), 64'd0);
    chk("t7_owner", 64'(owner), 64'd0);
    chk("t7_timeout", 64'(timeout), 64'd0);
    chk("t7_req_ready", 64'(req_ready), 64'd0);
    rst        = 1'b0;
    div_done   = 1'b1;
    div_result = 32'd14;
    tick();
    div_done = 1'b0;
    settle();
    chk("t7_late_done_busy", 64'(busy), 64'd0);
    chk("t7_late_done_rsp", 64'(rsp_valid), 64'd0);
    tick();
    settle();
    chk("t7_still_idle", 64'(rsp_valid), 64'd0);

    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Sequencer and two-way arbiter for the shared iterative divide unit in the execute datapath. It accepts divide requests from two requesters (lane 0 / lane 1) over valid/ready, grants round-robin, latches operands, and pulses the divider's start. It waits for done, then returns the result to the owning requester over valid/ready. Requester flushes are honoured by discarding the in-flight result, and a watchdog drops operations that never complete.

## Interface
- XLEN, 32, operand/result width
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before the op is dropped (≥ 2)

- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  2  request valid, one bit per requester
- req_ready_o  out  2  request accepted this cycle (one-hot or zero)
- req_a_i  in  2*XLEN  dividend; requester i at [i*XLEN +: XLEN]
- req_b_i  in  2*XLEN  divisor; same packing
- req_op_i  in  6  funct3 per requester; requester i at [i*3 +: 3]
- kill_i  in  2  flush of requester i; kills its pending or in-flight op
- rsp_valid_o  out  2  result valid for requester i (at most one bit set)
- rsp_data_o  out  XLEN  result data, shared by both requesters
- rsp_ready_i  in  2  requester i consumes the result
- div_start_o  out  1  single-cycle start pulse to the divide unit
- div_a_o, div_b_o  out  XLEN  latched operands, held stable from start until done
- div_op_o  out  3  latched funct3
- div_result_i  in  XLEN  divide unit result
- div_done_i  in  1  divide unit done pulse
- busy_o  out  1  state ≠ IDLE
- owner_o  out  1  index of the current owner; valid while busy_o
- timeout_o  out  1  one-cycle pulse when the watchdog drops an op

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP. Registers: state_q, owner_q, rr_q (priority pointer), killed_q, a/b/op latches, res_q, and a watchdog counter wd_q (width clog2(TIMEOUT_CYCLES+1)).
- IDLE:
  - eligible[i] = req_valid_i[i] & ~kill_i[i].
  - If both are eligible, requester rr_q wins. Otherwise the single eligible requester wins.
  - req_ready_o[g] = 1 combinationally for the winner only.
  - On the handshake: latch operands and op, owner_q ← g, rr_q ← ~g, killed_q ← 0, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - div_start_o = 1.
  - wd_q ← 0, go to WAIT.
  - kill_i[owner_q] sets killed_q.
- WAIT:
  - wd_q increments each cycle. kill_i[owner_q] sets killed_q.
  - On div_done_i:
    - If killed_q, or kill_i[owner_q] this cycle (kill wins over a simultaneous done), go to IDLE with no response.
    - Otherwise res_q ← div_result_i and go to RESP.
  - If there is no done and wd_q == TIMEOUT_CYCLES-1: timeout_o pulses, the op is dropped, go to IDLE.
- RESP:
  - rsp_valid_o[owner_q] = 1 and rsp_data_o = res_q; both are held until rsp_ready_i[owner_q], then go to IDLE.
  - kill_i[owner_q] in RESP drops the response in the same cycle (rsp_valid_o is forced to 0 combinationally), then go to IDLE.
- Signals ignored by the FSM:
  - div_done_i outside WAIT.
  - kill_i of the non-owner outside IDLE.
  - rsp_ready_i of the non-owner.
- The divider is never aborted. A killed op still occupies the unit until done or timeout.
- rsp_data_o is 0 whenever no rsp_valid_o bit is set.

## Timing
- Reset (rst_i sampled high at a clock edge):
  - state IDLE, rr_q = 0, owner_q = 0, killed_q = 0.
  - Latches, res_q and wd_q are 0.
  - All outputs are 0.
  - Any in-flight op is abandoned, and a later div_done_i is ignored.
- Latency, with the handshake at cycle T:
  - div_start_o is high in T+1.
  - The earliest accepted div_done_i is in T+2.
  - rsp_valid_o is asserted the cycle after done.
  - Minimum accept-to-rsp_valid latency is 3 cycles.
- Throughput: one op in flight. The next accept is possible no earlier than the cycle after the RESP handshake or the drop.
- req_ready_o depends only on state_q, rr_q, req_valid_i and kill_i. It never depends on rsp_ready_i.
- div_a_o, div_b_o and div_op_o are stable from ISSUE through WAIT.

## Test plan
- Single op:
  - Stimulus: req0 divides a=100, b=7, op=DIV. Model done 5 cycles after start; rsp_ready=1.
  - Response: div_start in T+1; rsp_valid_o=01 with data 14 at start+6; back to IDLE next cycle.
- Contention:
  - Stimulus: both requesters valid continuously from reset.
  - Response: grants alternate 0,1,0,1, with rr_q toggling after each grant.
- Kill in WAIT:
  - Stimulus: kill_i[1] asserted 2 cycles after start.
  - Response: the done pulse produces no rsp_valid_o; busy_o falls the cycle after done.
- Kill coincident with done:
  - Stimulus: kill and done in the same cycle.
  - Response: no response; IDLE next cycle.
- Backpressure:
  - Stimulus: rsp_ready low for 4 cycles.
  - Response: rsp_valid and data 14 held stable; completion on the ready cycle; req1 is not accepted meanwhile.
- Timeout and reset:
  - Stimulus: divider never asserts done.
  - Response: timeout_o pulses at WAIT cycle TIMEOUT_CYCLES, then IDLE.
  - Stimulus: rst_i raised in WAIT, then a late done arrives.
  - Response: all outputs are 0; no response is produced.
